// File: rtl/arm_cond_pkg.sv
// ARM condition-code constants, flag indices
// and controller state encoding.
package arm_cond_pkg;

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;
  localparam logic [3:0] CS = 4'b0010;
  localparam logic [3:0] CC = 4'b0011;
  localparam logic [3:0] MI = 4'b0100;
  localparam logic [3:0] PL = 4'b0101;
  localparam logic [3:0] VS = 4'b0110;
  localparam logic [3:0] VC = 4'b0111;
  localparam logic [3:0] HI = 4'b1000;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] LE = 4'b1101;
  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Condition-field evaluator: pass/fail of an
// ARM condition code against NZCV flags.
module cond_eval
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[N];
  assign z = flags[Z];
  assign c = flags[C];
  assign v = flags[V];

  // Straight truth table over all 16 codes
  always_comb begin
    pass = 1'b0;
    unique case (cond)
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c & !z;
      LS: pass = !c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution sequencer: owns NZCV,
// tracks in-flight flag writers, stalls/issues.
module cond_exec_ctrl
  import arm_cond_pkg::*;
#(
  parameter int MAX_PENDING  = 3,
  parameter int FLUSH_BUBBLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  output logic       id_ready,
  input  logic       wb_valid,
  input  logic [3:0] wb_flags,
  input  logic       flush,
  output logic       issue_valid,
  output logic       issue_exec,
  output logic       issue_s,
  output logic [3:0] sr_flags,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic       err_underflow
);

  localparam int PW = $clog2(MAX_PENDING+1);
  localparam logic [PW-1:0] PMAX =
    PW'(MAX_PENDING);
  localparam logic [2:0] BLOAD =
    3'(FLUSH_BUBBLE - 1);

  state_t     state, state_nx;
  logic [2:0] bcnt;
  logic [3:0] eff;
  logic       resolved;
  logic       uncond;
  logic       flag_stall;
  logic       full_stall;
  logic       stall_req;
  logic       pass;
  logic       accept;
  logic       inc, dec;

  assign uncond   = (id_cond[3:1] == 3'b111);
  assign resolved = (pending == '0) |
    ((pending == PW'(1)) & wb_valid);
  assign eff = (pending == '0) ?
    sr_flags : wb_flags;

  assign flag_stall = !uncond & !resolved;
  assign full_stall = id_s &
    (pending == PMAX) & !wb_valid;
  assign stall_req  = id_valid &
    (flag_stall | full_stall);

  cond_eval u_eval (
    .cond  (id_cond),
    .flags (eff),
    .pass  (pass)
  );

  assign accept = id_valid & id_ready;
  assign inc    = accept & id_s & pass;
  assign dec    = wb_valid & (pending != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next-state: flush wins, stall re-evaluated
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = FLUSH;
    end else begin
      unique case (state)
        RUN:     if (stall_req)  state_nx = STALL;
        STALL:   if (!stall_req) state_nx = RUN;
        FLUSH:   if (bcnt == '0) state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  // Output: accept only in RUN with no stall
  always_comb begin
    id_ready = (state == RUN) & !flag_stall &
      !full_stall & !flush;
  end

  // Bubble counter reloaded on every flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bcnt <= '0;
    else if (flush)
      bcnt <= BLOAD;
    else if (state == FLUSH && bcnt != '0)
      bcnt <= bcnt - 3'd1;
  end

  // Issue bundle registered one cycle after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_exec  <= 1'b0;
      issue_s     <= 1'b0;
    end else begin
      issue_valid <= accept;
      issue_exec  <= accept & pass;
      issue_s     <= inc;
    end
  end

  // SR takes every writeback, flush or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sr_flags <= '0;
    else if (wb_valid) sr_flags <= wb_flags;
  end

  // In-flight flag-writer count, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else if (flush)
      pending <= '0;
    else if (inc && !dec && pending != PMAX)
      pending <= pending + 1'b1;
    else if (dec && !inc)
      pending <= pending - 1'b1;
  end

  // Sticky flag for a writeback with nothing pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_underflow <= 1'b0;
    else if (wb_valid && pending == '0)
      err_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Randomised + directed bench for cond_exec_ctrl
// against a rule-level reference model.
module tb_cond_exec_ctrl;

  localparam int MAXP = 3;
  localparam int FB   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_cond = '0;
  logic       id_s = 1'b0;
  logic       id_ready;
  logic       wb_valid = 1'b0;
  logic [3:0] wb_flags = '0;
  logic       flush = 1'b0;
  logic       issue_valid;
  logic       issue_exec;
  logic       issue_s;
  logic [3:0] sr_flags;
  logic [1:0] pending;
  logic       err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_sr;
  int         m_pend;
  bit         m_err;
  int         m_mode;
  int         m_rem;

  cond_exec_ctrl #(
    .MAX_PENDING (MAXP),
    .FLUSH_BUBBLE(FB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_cond      (id_cond),
    .id_s         (id_s),
    .id_ready     (id_ready),
    .wb_valid     (wb_valid),
    .wb_flags     (wb_flags),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_exec   (issue_exec),
    .issue_s      (issue_s),
    .sr_flags     (sr_flags),
    .pending      (pending),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_pass(
    input logic [3:0] cond,
    input logic [3:0] f);
    bit n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond >= 4'd14) return 1'b1;
    case (cond[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      default: r = !z && (n == v);
    endcase
    return cond[0] ? !r : r;
  endfunction

  task automatic model_reset();
    m_sr = '0; m_pend = 0; m_err = 0;
    m_mode = 0; m_rem = 0;
  endtask

  task automatic step(input bit v,
                      input logic [3:0] c,
                      input bit s,
                      input bit w,
                      input logic [3:0] wf,
                      input bit fl);
    bit uncond, res, fst, full, rdy;
    bit acc, p, sc, e_iv, e_ie, e_is;
    logic [3:0] effv;
    int op;
    id_valid = v; id_cond = c; id_s = s;
    wb_valid = w; wb_flags = wf; flush = fl;
    #1;
    uncond = (c >= 4'd14);
    res  = (m_pend == 0) || (m_pend == 1 && w);
    effv = (m_pend == 0) ? m_sr : wf;
    fst  = !uncond && !res;
    full = s && m_pend == MAXP && !w;
    rdy  = m_mode == 0 && !fst && !full && !fl;
    chk("id_ready", int'(id_ready), int'(rdy));
    acc  = v && rdy;
    p    = ref_pass(c, effv);
    e_iv = acc;
    e_ie = acc && p;
    e_is = acc && s && p;
    sc   = v && (fst || full);
    op   = m_pend;
    if (w && op == 0) m_err = 1;
    if (w) m_sr = wf;
    if (fl) m_pend = 0;
    else begin
      m_pend = op + int'(e_is) -
        int'(w && op > 0);
      if (m_pend > MAXP) m_pend = MAXP;
    end
    if (fl) begin
      m_mode = 2; m_rem = FB;
    end else if (m_mode == 0) begin
      if (sc) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!sc) m_mode = 0;
    end else begin
      m_rem--;
      if (m_rem == 0) m_mode = 0;
    end
    @(posedge clk);
    #1;
    chk("issue_valid", int'(issue_valid),
        int'(e_iv));
    chk("issue_exec", int'(issue_exec),
        int'(e_ie));
    chk("issue_s", int'(issue_s), int'(e_is));
    chk("sr_flags", int'(sr_flags), int'(m_sr));
    chk("pending", int'(pending), m_pend);
    chk("err_underflow", int'(err_underflow),
        int'(m_err));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_iv"}, int'(issue_valid), 0);
    chk({tag, "_ie"}, int'(issue_exec), 0);
    chk({tag, "_is"}, int'(issue_s), 0);
    chk({tag, "_sr"}, int'(sr_flags), 0);
    chk({tag, "_pend"}, int'(pending), 0);
    chk({tag, "_err"}, int'(err_underflow), 0);
  endtask

  initial begin
    bit v, s, w, fl;
    logic [3:0] c, wf;
    model_reset();
    #3;
    chk_zero("rst");
    #9;
    rst = 1'b0;

    step(1, 4'b0000, 0, 0, 4'h0, 0);
    chk("eq_iv", int'(issue_valid), 1);
    chk("eq_exec", int'(issue_exec), 0);

    step(1, 4'b1110, 1, 0, 4'h0, 0);
    chk("s_pend1", int'(pending), 1);
    step(1, 4'b0001, 0, 0, 4'h0, 0);
    step(1, 4'b0001, 0, 0, 4'h0, 0);
    step(1, 4'b0001, 0, 1, 4'b0100, 0);
    chk("byp_sr", int'(sr_flags), 4);
    chk("byp_pend", int'(pending), 0);
    step(1, 4'b0001, 0, 0, 4'h0, 0);
    chk("ne_exec", int'(issue_exec), 0);

    for (int i = 0; i < 3; i++)
      step(1, 4'b1110, 1, 0, 4'h0, 0);
    chk("sat_pend", int'(pending), 3);
    step(1, 4'b1110, 1, 0, 4'h0, 0);
    step(1, 4'b1110, 1, 1, 4'h2, 0);
    step(1, 4'b1110, 1, 0, 4'h0, 0);
    chk("sat_pend3", int'(pending), 3);
    step(1, 4'b1110, 1, 1, 4'h3, 0);
    chk("sat_same", int'(pending), 3);
    chk("sat_iv", int'(issue_valid), 1);

    step(0, 4'b1110, 0, 1, 4'h0, 0);
    step(1, 4'b0001, 0, 0, 4'h0, 0);
    step(1, 4'b1010, 0, 1, 4'b1001, 1);
    chk("fl_pend", int'(pending), 0);
    chk("fl_sr", int'(sr_flags), 9);
    step(1, 4'b1010, 0, 0, 4'h0, 0);
    step(1, 4'b1010, 0, 0, 4'h0, 0);
    chk("ge_exec", int'(issue_exec), 1);

    step(0, 4'b0000, 0, 1, 4'h0, 0);
    chk("uf_err", int'(err_underflow), 1);
    chk("uf_sr", int'(sr_flags), 0);
    step(1, 4'b0000, 1, 0, 4'h0, 0);
    chk("fs_exec", int'(issue_exec), 0);
    chk("fs_s", int'(issue_s), 0);
    chk("fs_pend", int'(pending), 0);

    step(1, 4'b1110, 1, 0, 4'h0, 0);
    step(1, 4'b0000, 0, 0, 4'h0, 0);
    step(1, 4'b0000, 0, 0, 4'h0, 0);
    rst = 1'b1;
    #2;
    chk_zero("arst");
    model_reset();
    rst = 1'b0;
    #1;

    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 99) < 75);
      c  = 4'($urandom_range(0, 15));
      s  = ($urandom_range(0, 99) < 50);
      w  = (m_pend > 0) &&
           ($urandom_range(0, 99) < 35);
      wf = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 99) < 4);
      step(v, c, s, w, wf, fl);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
